md5_pipe_ctrl: RTL

//  Sequences candidate 512-bit padded blocks into the 64-stage md5core pipeline (65 enabled cycles in-to-out).

---
 rtl/md5_pkg.sv | 28 ++
 rtl/md5_token_pipe.sv | 48 ++++
 rtl/md5_pipe_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// +------------------------------------------------------------------------+
// | Package : md5_pkg                                                      |
// | Purpose : Shared constants for the MD5 pipeline controller: pipeline   |
// |           depth, controller state encodings, MD5 chaining IVs.         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

package md5_pkg;

  // Enabled cycles from mesg capture to a valid digest at md5core outputs.
  localparam int MD5_PIPE_DEPTH = 65;

  // Controller state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // MD5 initial chaining values.
  localparam logic [31:0] MD5_A0 = 32'h67452301;
  localparam logic [31:0] MD5_B0 = 32'hefcdab89;
  localparam logic [31:0] MD5_C0 = 32'h98badcfe;
  localparam logic [31:0] MD5_D0 = 32'h10325476;

endpackage

`default_nettype wire

// File: rtl/md5_token_pipe.sv
// +------------------------------------------------------------------------+
// | Module  : md5_token_pipe                                               |
// | Purpose : DEPTH-stage enabled shift register of {valid, tag} tokens    |
// |           that tracks md5core stage occupancy, with a tail-clear used  |
// |           when a held hit is consumed.                                 |
// | Ports   : clk, reset (sync, active-high), en (advance one place),     |
// |           clr_tail (drop tail valid), in_valid/in_tag (slot 0 data),   |
// |           tail_valid/tail_tag (token at stage DEPTH-1).                |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module md5_token_pipe #(
  parameter int DEPTH = 65,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr_tail,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             tail_valid,
  output logic [TAG_W-1:0] tail_tag
);

  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH*TAG_W-1:0] tags_q;

  // Tags shift unconditionally with en; only the valid bits carry meaning.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      tags_q  <= '0;
    end else if (en) begin
      valid_q <= {valid_q[DEPTH-2:0], in_valid};
      tags_q  <= {tags_q[(DEPTH-1)*TAG_W-1:0], in_tag};
    end else if (clr_tail) begin
      valid_q[DEPTH-1] <= 1'b0;
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_tag   = tags_q[DEPTH*TAG_W-1 -: TAG_W];

endmodule

`default_nettype wire

// File: rtl/md5_pipe_ctrl.sv
// +------------------------------------------------------------------------+
// | Module  : md5_pipe_ctrl                                                |
// | Purpose : Feeds candidate blocks into the md5core pipeline, tracks a   |
// |           valid/tag token per stage, compares retiring digests with a  |
// |           loaded target and holds the pipeline while a hit is pending. |
// | Ports   : start/target/flush control; in_valid/in_ready/in_mesg/in_tag |
// |           candidate input; core_en/core_mesg/core_a..d md5core side;   |
// |           match_valid/match_ready/match_tag hit output; busy, done,    |
// |           pipe_count status.                                           |
// | Config  : MD5_CTRL_STATS_EN adds hash_count[47:0] (retired tokens,     |
// |           cleared on start, saturating).                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module md5_pipe_ctrl
  import md5_pkg::*;
#(
  parameter int  PIPE_DEPTH = MD5_PIPE_DEPTH,
  parameter int  TAG_W      = 32,
  localparam int CNT_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [127:0]     target,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_mesg,
  input  logic [TAG_W-1:0] in_tag,
  output logic             core_en,
  output logic [511:0]     core_mesg,
  input  logic [31:0]      core_a,
  input  logic [31:0]      core_b,
  input  logic [31:0]      core_c,
  input  logic [31:0]      core_d,
  output logic             match_valid,
  input  logic             match_ready,
  output logic [TAG_W-1:0] match_tag,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pipe_count
`ifdef MD5_CTRL_STATS_EN
  ,
  output logic [47:0]      hash_count
`endif
);

  logic [1:0]       state_q, state_d;
  logic             ret_drain_q, ret_drain_d;
  logic [127:0]     target_q;
  logic [CNT_W-1:0] pipe_count_q, pipe_count_d;

  logic             tail_valid;
  logic [TAG_W-1:0] tail_tag;
  logic             hit, ready, accept, advance, retire, consume, active;

  // Hit is evaluated on the tail token; while it is asserted md5core is frozen,
  // so the same digest stays on core_a..d until the hit is consumed.
  assign hit     = tail_valid && ({core_a, core_b, core_c, core_d} == target_q);
  assign active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign ready   = (state_q == ST_RUN) && !hit && !flush;
  assign accept  = in_valid && ready;
  // Bubbles are only clocked in while something is in flight.
  assign advance = active && !hit && (accept || (pipe_count_q != '0));
  assign retire  = advance && tail_valid;
  assign consume = (state_q == ST_HOLD) && match_ready;

  md5_token_pipe #(
    .DEPTH (PIPE_DEPTH),
    .TAG_W (TAG_W)
  ) u_tokens (
    .clk        (clk),
    .reset      (reset),
    .en         (advance),
    .clr_tail   (consume),
    .in_valid   (accept),
    .in_tag     (in_tag),
    .tail_valid (tail_valid),
    .tail_tag   (tail_tag)
  );

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ret_drain_q  <= 1'b0;
      target_q     <= '0;
      pipe_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ret_drain_q  <= ret_drain_d;
      pipe_count_q <= pipe_count_d;
      if ((state_q == ST_IDLE) && start) target_q <= target;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ret_drain_d = ret_drain_q;
    case (state_q)
      ST_IDLE: begin
        ret_drain_d = 1'b0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A flush coinciding with a hit is remembered for the HOLD exit.
        if (hit) begin
          state_d     = ST_HOLD;
          ret_drain_d = flush;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hit) begin
          state_d     = ST_HOLD;
          ret_drain_d = 1'b1;
        end else if (pipe_count_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (flush) ret_drain_d = 1'b1;
        if (match_ready) state_d = (ret_drain_q || flush) ? ST_DRAIN : ST_RUN;
      end
    endcase
  end

  // In-flight count; accept and retire/consume in one cycle cancel out.
  always_comb begin
    pipe_count_d = pipe_count_q;
    if (accept && !(retire || consume))
      pipe_count_d = pipe_count_q + CNT_W'(1);
    else if (!accept && (retire || consume))
      pipe_count_d = pipe_count_q - CNT_W'(1);
  end

  // Output logic
  always_comb begin
    in_ready    = ready;
    core_en     = advance;
    core_mesg   = accept ? in_mesg : '0;
    match_valid = (state_q == ST_HOLD);
    match_tag   = (state_q == ST_HOLD) ? tail_tag : '0;
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DRAIN) && (pipe_count_q == '0) && !hit;
    pipe_count  = pipe_count_q;
  end

`ifdef MD5_CTRL_STATS_EN
  logic [47:0] hash_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hash_count_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      hash_count_q <= '0;
    end else if ((retire || consume) && !(&hash_count_q)) begin
      hash_count_q <= hash_count_q + 48'd1;
    end
  end

  assign hash_count = hash_count_q;
`endif

endmodule

`default_nettype wire
